// File: rtl/div_unit_if.sv
// Divider request/result bundle: operands and mode in, quotient/remainder and status out.
// Latency: none; a plain wire bundle with no storage.
// Backpressure: none here; the requester watches busy/done and holds off while the divider works.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Requester side (execute stage control).
    modport master (
        output start, sign, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    // Divider side.
    modport slave (
        input  start, sign, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU; HI = r (remainder), LO = q (quotient). Macro DIV_EARLY_OUT_EN enables early out.
// Latency: done WIDTH+2 edges after accept; divide-by-zero (and early out when enabled) in 2.
// Backpressure: start is taken only when idle and not in the done cycle; start while busy is dropped.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_ZERO,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] rem;       // partial remainder; holds the raw dividend on the zero path
    logic [WIDTH-1:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dvs_zero;
    logic             early;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;

    // Operand magnitudes, accept qualification and one restoring step.
    always_comb begin
        abs_dvd  = (bus.sign && bus.dividend[WIDTH-1]) ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        abs_dvs  = (bus.sign && bus.divisor[WIDTH-1])  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
        dvs_zero = (bus.divisor == '0);
        // The done cycle is already idle, so it is excluded explicitly to defer a new start by one cycle.
        accept   = (state == S_IDLE) && bus.start && !bus.done;
`ifdef DIV_EARLY_OUT_EN
        early    = !dvs_zero && (abs_dvs > abs_dvd);
`else
        early    = 1'b0;
`endif
        // One extra bit so a shifted remainder up to 2*divisor-1 never wraps.
        shifted  = {rem, quo[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs});
        rem_nxt  = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: CALC for WIDTH cycles, FIX applies signs, DONE raises the done pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dvs_zero) begin
                        state_nxt = S_ZERO;
                    end else if (early) begin
                        state_nxt = S_FIX;   // quotient is known to be zero, skip the iterations
                    end else begin
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC:  if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_ZERO:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift/subtract iterations, result load and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.q        <= '0;
            bus.r        <= '0;
            bus.div_zero <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            // Status lags the state by one edge: busy spans the edge after accept up to done.
            bus.busy <= (state == S_CALC) || (state == S_FIX) || (state == S_ZERO);
            bus.done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dvs   <= abs_dvs;
                        cnt   <= '0;
                        neg_q <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r <= bus.sign && bus.dividend[WIDTH-1];
                        if (dvs_zero) begin
                            rem <= bus.dividend;
                            quo <= '0;
                        end else if (early) begin
                            // FIX re-applies the dividend sign, so r returns the original dividend.
                            rem <= abs_dvd;
                            quo <= '0;
                        end else begin
                            rem <= '0;
                            quo <= abs_dvd;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    // Truncation toward zero; remainder follows the dividend sign.
                    bus.q        <= neg_q ? (~quo + WIDTH'(1)) : quo;
                    bus.r        <= neg_r ? (~rem + WIDTH'(1)) : rem;
                    bus.div_zero <= 1'b0;
                end
                S_ZERO: begin
                    bus.q        <= '1;
                    bus.r        <= rem;
                    bus.div_zero <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    logic clk;
    logic rst_n;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          elat;
    } vec_t;

    vec_t vecs[15];

    int n_total;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the divider idle; returns after the done cycle has passed.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] oq, output logic [31:0] orr, output logic odz,
                          output int lat, output int bcnt);
        bus.start    = 1'b1;
        bus.sign     = sg;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
        oq  = bus.q;
        orr = bus.r;
        odz = bus.div_zero;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] q_o;
        logic [31:0] r_o;
        logic        dz_o;
        int          lat;
        int          bcnt;
        int          ndone;
        int          d1;
        int          d2;
        int          cyc;

        n_total = 0;
        n_pass  = 0;

        //         sg    dividend      divisor       q             r             dz    lat
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
        vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
        vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 2};
        vecs[4]  = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 34};
        vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
        vecs[6]  = '{1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, EO_LAT};
        vecs[7]  = '{1'b1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b0, EO_LAT};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34};
        vecs[11] = '{1'b1, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, EO_LAT};
        vecs[12] = '{1'b0, 32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34};
        vecs[13] = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 2};
        vecs[14] = '{1'b0, 32'h12345678, 32'h10,       32'h01234567, 32'd8,        1'b0, 34};

        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;

        #3;
        chk("reset_q",        bus.q,               32'd0);
        chk("reset_r",        bus.r,               32'd0);
        chk("reset_busy",     {31'd0, bus.busy},   32'd0);
        chk("reset_done",     {31'd0, bus.done},   32'd0);
        chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, q_o, r_o, dz_o, lat, bcnt);
            chk($sformatf("vec%0d_q", i),   q_o,               vecs[i].eq);
            chk($sformatf("vec%0d_r", i),   r_o,               vecs[i].er);
            chk($sformatf("vec%0d_dz", i),  {31'd0, dz_o},     {31'd0, vecs[i].edz});
            chk($sformatf("vec%0d_lat", i), 32'(lat),          32'(vecs[i].elat));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].elat - 1));
        end

        // start pulsed mid-CALC with different operands must be ignored.
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0; d1 = 0; q_o = '0; r_o = '0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin
                bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
            end
            if (c == 11) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (d1 == 0) begin
                    d1 = c; q_o = bus.q; r_o = bus.r;
                end
            end
        end
        chk("midcalc_done_pulses", 32'(ndone), 32'd1);
        chk("midcalc_lat",         32'(d1),    32'd34);
        chk("midcalc_q",           q_o,        32'd14);
        chk("midcalc_r",           r_o,        32'd2);

        // start held through the done cycle: taken only on the following cycle.
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk); #1;
        d1 = 0; d2 = 0; cyc = 0;
        while (cyc < 120 && d2 == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) begin
                if (d1 == 0) d1 = cyc;
                else begin
                    d2 = cyc; q_o = bus.q;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("held_first_done",  32'(d1), 32'd34);
        chk("held_second_done", 32'(d2), 32'd70);
        chk("held_second_q",    q_o,     32'd3);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q",        bus.q,                 32'd0);
        chk("arst_r",        bus.r,                 32'd0);
        chk("arst_busy",     {31'd0, bus.busy},     32'd0);
        chk("arst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);

        run_op(1'b0, 32'd9, 32'd3, q_o, r_o, dz_o, lat, bcnt);
        chk("post_arst_q",   q_o,      32'd3);
        chk("post_arst_r",   r_o,      32'd0);
        chk("post_arst_lat", 32'(lat), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
